// File: rtl/fetch_controller.sv
// Instruction fetch controller: program-load port in IDLE/HALT, sequential fetch with stall/redirect in FETCH.
// Optional macro HALT_ON_ZERO_EN: a fetched all-zero word halts the controller instead of issuing.
module fetch_controller #(
   parameter int              PC_W     = 10,
   parameter int              DATA_W   = 32,
   parameter logic [PC_W-1:0] RESET_PC = {PC_W{1'b0}}
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              run,
   input  logic              stall,
   input  logic              redirect_valid,
   input  logic [PC_W-1:0]   redirect_pc,
   input  logic              load_valid,
   input  logic [PC_W-1:0]   load_addr,
   input  logic [DATA_W-1:0] load_data,
   output logic              load_ready,
   output logic [PC_W-1:0]   mem_addr,
   output logic              mem_we,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              instr_valid,
   output logic [DATA_W-1:0] instr,
   output logic [PC_W-1:0]   instr_pc,
   output logic              halted
);

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_FETCH = 2'd1;
   localparam logic [1:0] ST_HALT  = 2'd2;

   localparam logic [PC_W-1:0] PC_ONE = {{(PC_W-1){1'b0}}, 1'b1};

   logic [1:0]        state_q, state_d;
   logic [PC_W-1:0]   pc_q, pc_d;
   logic [DATA_W-1:0] instr_q, instr_d;
   logic [PC_W-1:0]   instr_pc_q, instr_pc_d;
   logic              instr_valid_q, instr_valid_d;
   logic              fetching_s;

   assign fetching_s = (state_q == ST_FETCH);

   // Next-state and fetch pipeline logic
   always_comb begin
      state_d       = state_q;
      pc_d          = pc_q;
      instr_d       = instr_q;
      instr_pc_d    = instr_pc_q;
      instr_valid_d = instr_valid_q;
      case (state_q)
         ST_IDLE: begin
            instr_valid_d = 1'b0;
            // A simultaneous load takes the cycle; the fetch start waits one cycle.
            if (run && !load_valid) begin
               state_d = ST_FETCH;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_FETCH: begin
            if (!run) begin
               state_d       = ST_IDLE;
               instr_valid_d = 1'b0;
            end else if (redirect_valid) begin
               pc_d          = redirect_pc;
               instr_valid_d = 1'b0;
            end else if (stall) begin
               state_d = ST_FETCH;
`ifdef HALT_ON_ZERO_EN
            end else if (mem_rdata == {DATA_W{1'b0}}) begin
               state_d       = ST_HALT;
               instr_valid_d = 1'b0;
`endif
            end else begin
               instr_d       = mem_rdata;
               instr_pc_d    = pc_q;
               instr_valid_d = 1'b1;
               pc_d          = pc_q + PC_ONE;
            end
         end
         ST_HALT: begin
            instr_valid_d = 1'b0;
            if (!run) begin
               state_d = ST_IDLE;
               pc_d    = RESET_PC;
            end else begin
               state_d = ST_HALT;
            end
         end
         default: begin
            state_d       = ST_IDLE;
            instr_valid_d = 1'b0;
         end
      endcase
   end

   // State and fetch registers with asynchronous reset
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q       <= ST_IDLE;
         pc_q          <= RESET_PC;
         instr_q       <= {DATA_W{1'b0}};
         instr_pc_q    <= {PC_W{1'b0}};
         instr_valid_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         pc_q          <= pc_d;
         instr_q       <= instr_d;
         instr_pc_q    <= instr_pc_d;
         instr_valid_q <= instr_valid_d;
      end
   end

   // Memory port: load path outside FETCH, writes suppressed while in reset
   always_comb begin
      load_ready = !rst && !fetching_s;
      mem_we     = load_ready && load_valid;
      if (mem_we) begin
         mem_addr  = load_addr;
         mem_wdata = load_data;
      end else begin
         mem_addr  = pc_q;
         mem_wdata = {DATA_W{1'b0}};
      end
   end

   assign instr_valid = instr_valid_q;
   assign instr       = instr_q;
   assign instr_pc    = instr_pc_q;
`ifdef HALT_ON_ZERO_EN
   assign halted      = (state_q == ST_HALT);
`else
   assign halted      = 1'b0;
`endif

endmodule
